// File: rtl/rle_pkg.sv
// Shared definitions for the RLE colour path: widths, token layout and the
// count-zero convention used by both encoder and decoder.
package rle_pkg;

   localparam int unsigned COUNT_W_DEFAULT = 8;
   localparam int unsigned DATA_W_DEFAULT  = 32;

   // A run length of zero stands for the largest run, 2^COUNT_W words.
   localparam bit COUNT_ZERO_MEANS_MAX = 1'b1;

   typedef struct packed {
      logic [COUNT_W_DEFAULT-1:0] count;
      logic [DATA_W_DEFAULT-1:0]  data;
      logic                       last;
   } rle_token_t;

   typedef enum logic {
      StIdle,
      StRun
   } rle_dec_state_t;

endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter holding the words still to emit for the current run.
// Load takes priority over decrement so a reload on the final word has no bubble.
module rle_run_counter
   import rle_pkg::*;
#(
   parameter int unsigned COUNT_W = COUNT_W_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic [COUNT_W-1:0] count,
   input  logic               dec,
   output logic               is_one,
   output logic               empty
);

   logic [COUNT_W:0] remain_q, remain_d, load_val;

   always_comb begin
      load_val = {1'b0, count};
      if (COUNT_ZERO_MEANS_MAX && count == '0) begin
         load_val = {1'b1, {COUNT_W{1'b0}}};
      end
      remain_d = remain_q;
      if (load) begin
         remain_d = load_val;
      end else if (dec && remain_q != '0) begin
         remain_d = remain_q - (COUNT_W+1)'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         remain_q <= '0;
      end else begin
         remain_q <= remain_d;
      end
   end

   assign is_one = (remain_q == (COUNT_W+1)'(1));
   assign empty  = (remain_q == '0);

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (count, colour) tokens into a stream of colour
// words, one per clock, and tracks the number of words emitted in the frame.
module rle_decoder
   import rle_pkg::*;
#(
   parameter int unsigned COUNT_W = COUNT_W_DEFAULT,
   parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COUNT_W-1:0] in_count,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_last,
   output logic [31:0]        frame_words
);

   rle_dec_state_t    state_q, state_d;
   logic [DATA_W-1:0] data_q;
   logic              last_q;
   logic [31:0]       frame_words_q, frame_words_d;
   logic              accept, fire, is_one, empty;

   rle_run_counter #(
      .COUNT_W (COUNT_W)
   ) u_run_counter (
      .clock  (clock),
      .reset  (reset),
      .load   (accept),
      .count  (in_count),
      .dec    (fire),
      .is_one (is_one),
      .empty  (empty)
   );

   assign out_valid   = (state_q == StRun);
   // A new token is taken while idle or as the current run's final word leaves.
   assign in_ready    = !reset && (!out_valid || (out_ready && is_one));
   assign accept      = in_valid && in_ready;
   assign fire        = out_valid && out_ready;
   assign out_data    = data_q;
   assign out_last    = out_valid && last_q && is_one;
   assign frame_words = frame_words_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StRun;
         StRun:  if (!accept && ((fire && is_one) || empty)) state_d = StIdle;
      endcase
   end

   always_comb begin
      frame_words_d = frame_words_q;
      if (fire) begin
         if (out_last) begin
            frame_words_d = '0;
         end else if (frame_words_q != '1) begin
            frame_words_d = frame_words_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         data_q        <= '0;
         last_q        <= 1'b0;
         frame_words_q <= '0;
      end else begin
         state_q       <= state_d;
         frame_words_q <= frame_words_d;
         if (accept) begin
            data_q <= in_data;
            last_q <= in_last;
         end
      end
   end

endmodule

// File: doc/rle_decoder.md
# rle_decoder

Run-length decoder for the RLE colour path. Accepts (count, colour) tokens and expands each into `count` consecutive 32-bit colour words at one word per clock. Its output stream has the same form as the word stream the colour buffer consumes. Sits at the far end of the RLE link, between the token source and the colour buffer/pixel sink.

## Interface
- `COUNT_W`, default 8: width of the run-length field; count 0 encodes 2^COUNT_W.
- `DATA_W`, default 32: colour word width.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_valid` input 1: token present.
- `in_ready` output 1: decoder accepts token this cycle.
- `in_count` input COUNT_W: run length.
- `in_data` input DATA_W: colour value to repeat.
- `in_last` input 1: token is the final token of a frame.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: sink accepts word.
- `out_data` output DATA_W: expanded colour word.
- `out_last` output 1: final word of the frame; qualified by `out_valid`.
- `frame_words` output 32: words emitted so far in the current frame.

## Operation
- State registers: `data_q`, `remain_q` (COUNT_W+1 bits), `last_q`, `out_valid`, `frame_words`.
- State machine:
  - IDLE (`out_valid`=0).
  - RUN (`out_valid`=1, `remain_q`≥1).
- Input handshake: a token is accepted when `in_valid && in_ready`.
- `in_ready` = !reset && (!out_valid || (out_ready && remain_q==1)). Combinational; takes a new token in IDLE or on the cycle the current run's last word is taken.
- On accept:
  - `data_q`←`in_data`.
  - `remain_q`←(`in_count`==0 ? 2^COUNT_W : `in_count`).
  - `last_q`←`in_last`.
  - `out_valid`←1.
- Output handshake: a word fires when `out_valid && out_ready`.
- Word fires with no accept that cycle: `remain_q`←`remain_q`−1. If `remain_q` was 1, `out_valid`←0 (return to IDLE).
- Fire and accept in the same cycle: accept wins and reloads all registers (RUN→RUN, no bubble).
- `out_data`=`data_q`. It is held stable while `out_valid && !out_ready`. Upstream changes cannot disturb it, because `in_ready`=0 in that condition.
- `out_last` = `out_valid && last_q && remain_q==1`.
- `frame_words`:
  - Increments by 1 on each fire.
  - On a fire with `out_last`=1, it goes to 0 instead.
  - Saturates at 2^32−1.
- `in_count`, `in_data` and `in_last` are ignored when `in_valid`=0.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `in_ready`=0.
  - `frame_words`=0, `remain_q`=0, `last_q`=0.
- `in_ready` rises combinationally in the first cycle after reset deasserts.
- Latency: token accepted at edge t → first word valid after edge t, i.e. during cycle t+1.
- Throughput: one word per cycle with `out_ready` held high, including across token boundaries.
- A token of count N occupies exactly N output cycles under no backpressure.
- Backpressure: `out_ready`=0 freezes `remain_q`, `data_q` and `out_last`.
- Reset mid-run: the partial run is discarded and the decoder returns to IDLE. No word from the discarded run appears after reset.
- Count 0 with COUNT_W=8 gives a 256-word run. `remain_q` is wide enough to hold 256.

## Structure
- Shared package `rle_pkg`:
  - `COUNT_W` and `DATA_W` defaults.
  - Token field layout shared with the encoder (count, data, last).
  - The `COUNT_ZERO_MEANS_MAX` convention constant.
- Natural sub-module: `rle_run_counter`. It is the loadable down-counter holding `remain_q`, with `load`, `dec`, `is_one` and `empty` outputs. The FSM, handshake and frame counter stay in `rle_decoder`.

## Test plan
- Reset then single token (count=3, data=32'h00FF00FF, last=1), `out_ready`=1 → exactly 3 words 32'h00FF00FF on cycles t+1..t+3. `out_last` on the 3rd only. `frame_words` returns to 0.
- Back-to-back tokens (2, 32'hFFFF), (1, 32'h0FFF), (4, 32'h000F, last) → 7 contiguous words with no bubble. `in_ready` is high on the final word of each run.
- Count=0 token, data=32'h00FF, last=1 → 256 words. `out_last` on word 256 only. `frame_words` reaches 255 before the clear.
- Backpressure: token (5, 32'hABCD) with `out_ready` toggling 1,0,0,1,… → 5 words total. `out_data` is stable and `in_ready`=0 while stalled.
- Reset asserted after 2 of 6 words of a run → `out_valid` drops asynchronously. No further words after release. The next token (1, 32'h0) is decoded normally.
- `in_valid` low with garbage on `in_count`/`in_data` → no output, `frame_words` unchanged.
